bcd_serial_addsub: RTL and testbench

//  Digit-serial N-digit packed-BCD adder/subtractor with start/done handshake.

---
 rtl/bcd_serial_addsub.sv | 142 ++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_serial_addsub                                                |
// | Brief   : digit-serial packed-BCD add/subtract, sign+magnitude result.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   o,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] c_last = IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_RUN  = 3'd2,
        S_COMP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [4*DIGITS-1:0] r_a, r_b, r_o;
    logic [IW-1:0]       r_idx;
    logic                r_carry, r_sub, r_cout, r_neg, r_err;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    logic w_accept, w_in_bad, w_op_bad, w_is_last;
    assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_in_bad  = has_bad_digit(a) | has_bad_digit(b);
    assign w_op_bad  = has_bad_digit(r_a) | has_bad_digit(r_b);
    assign w_is_last = (r_idx == c_last);

    // Single digit slice; COMP reuses it as 0 + (9 - r_i) + carry.
    logic [3:0] w_x, w_y_raw, w_y, w_digit;
    logic [4:0] w_s;
    logic       w_c;
    assign w_x     = (r_state == S_COMP) ? 4'd0 : r_a[3:0];
    assign w_y_raw = (r_state == S_COMP) ? r_o[3:0] : r_b[3:0];
    assign w_y     = (r_state == S_COMP || r_sub) ? (4'd9 - w_y_raw) : w_y_raw;
    assign w_s     = {1'b0, w_x} + {1'b0, w_y} + {4'd0, r_carry};
    assign w_c     = w_s[4] | (w_s[3:0] > 4'd9);
    assign w_digit = w_c ? (w_s[3:0] + 4'd6) : w_s[3:0];

    logic [4*DIGITS+3:0] w_cat;
    assign w_cat = {w_digit, r_o};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_in_bad ? S_DONE : S_CHK;
            S_CHK:  w_next = w_op_bad ? S_DONE : S_RUN;
            S_RUN:  if (w_is_last) w_next = (r_sub && !w_c) ? S_COMP : S_DONE;
            S_COMP: if (w_is_last) w_next = S_DONE;
            S_DONE: w_next = w_accept ? (w_in_bad ? S_DONE : S_CHK) : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_o     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_cout  <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            // Malformed operands are flagged here so err reports one cycle after accept.
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_o     <= '0;
            r_cout  <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= w_in_bad;
            r_idx   <= '0;
            r_carry <= sub;
        end else begin
            case (r_state)
                S_CHK: if (w_op_bad) r_err <= 1'b1;
                S_RUN: begin
                    r_o     <= w_cat[4*DIGITS+3:4];
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_c;
                    r_idx   <= r_idx + IW'(1);
                    if (w_is_last) begin
                        r_cout  <= w_c;
                        r_idx   <= '0;
                        r_carry <= 1'b1;
                    end
                end
                S_COMP: begin
                    r_o     <= w_cat[4*DIGITS+3:4];
                    r_carry <= w_c;
                    r_idx   <= r_idx + IW'(1);
                    if (w_is_last) r_neg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN) || (r_state == S_COMP);
    assign done = (r_state == S_DONE);
    assign o    = r_o;
    assign cout = r_cout;
    assign neg  = r_neg;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bcd_serial_addsub                                             |
// | Brief   : random + directed check of bcd_serial_addsub against a model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst, start, sub;
    logic [15:0] a, b, o;
    logic        busy, done, cout, neg, err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .o(o), .cout(cout), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit bad_bcd(input logic [15:0] v);
        bit r;
        r = 0;
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) r = 1;
        return r;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int m;
        m = n;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
        a = ta; b = tb; sub = ts; start = 1'b1;
    endtask

    // Edge count starts at the accepting edge, so cycle T+k is observed at count k-1.
    task automatic finish_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                             input int inj, input bit chain);
        int lat, nbusy, ea, eb, res;
        int exp_lat, exp_busy;
        logic [15:0] exp_o;
        logic exp_cout, exp_neg, exp_err;

        ea = bcd2int(ta);
        eb = bcd2int(tb);
        exp_err = bad_bcd(ta) || bad_bcd(tb);
        exp_neg = 1'b0;
        if (exp_err) begin
            exp_o = '0; exp_cout = 1'b0; exp_lat = 0; exp_busy = 0;
        end else if (!ts) begin
            res = ea + eb;
            exp_o = int2bcd(res % 10000); exp_cout = (res >= 10000);
            exp_lat = DIGITS + 1; exp_busy = DIGITS;
        end else if (ea >= eb) begin
            exp_o = int2bcd(ea - eb); exp_cout = 1'b1;
            exp_lat = DIGITS + 1; exp_busy = DIGITS;
        end else begin
            exp_o = int2bcd(eb - ea); exp_cout = 1'b0; exp_neg = 1'b1;
            exp_lat = 2 * DIGITS + 1; exp_busy = 2 * DIGITS;
        end

        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nbusy = 0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            if (lat == inj) begin
                a = 16'h9999; b = 16'h0001; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("latency",   32'(lat), 32'(exp_lat));
        check_eq("busy_cyc",  32'(nbusy), 32'(exp_busy));
        check_eq("o",         32'(o), 32'(exp_o));
        check_eq("cout",      32'(cout), 32'(exp_cout));
        check_eq("neg",       32'(neg), 32'(exp_neg));
        check_eq("err",       32'(err), 32'(exp_err));
        if (!chain) begin
            @(posedge clk); #1;
            check_eq("done_pulse", 32'(done), 32'd0);
            check_eq("o_hold",     32'(o), 32'(exp_o));
        end
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts, input int inj);
        @(negedge clk);
        start_op(ta, tb, ts);
        finish_op(ta, tb, ts, inj, 1'b0);
    endtask

    initial begin
        int ndone;
        logic [15:0] ra, rb;
        logic rs;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_o",    32'(o), 32'd0);
        check_eq("rst_flags", 32'({cout, neg, err}), 32'd0);
        @(negedge clk); rst = 1'b0;

        do_op(16'h1234, 16'h5678, 1'b0, -1);
        do_op(16'h9999, 16'h0001, 1'b0, -1);
        do_op(16'h0345, 16'h0345, 1'b1, -1);
        do_op(16'h5000, 16'h1234, 1'b1, -1);
        do_op(16'h0012, 16'h0345, 1'b1, -1);
        do_op(16'h12A4, 16'h0000, 1'b0, -1);
        do_op(16'h0000, 16'h0000, 1'b1, -1);

        // start during RUN with different operands must be ignored
        do_op(16'h1234, 16'h5678, 1'b0, 2);

        // back-to-back: start held on the done cycle
        @(negedge clk);
        start_op(16'h0012, 16'h0345, 1'b1);
        finish_op(16'h0012, 16'h0345, 1'b1, -1, 1'b1);
        start_op(16'h4321, 16'h8765, 1'b0);
        finish_op(16'h4321, 16'h8765, 1'b0, -1, 1'b1);
        start_op(16'hF000, 16'h0001, 1'b1);
        finish_op(16'hF000, 16'h0001, 1'b1, -1, 1'b0);

        // reset in the middle of RUN
        @(negedge clk);
        start_op(16'h1234, 16'h5678, 1'b0);
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_o",    32'(o), 32'd0);
        check_eq("midrst_flags", 32'({cout, neg, err}), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check_eq("midrst_quiet", 32'(ndone), 32'd0);

        for (int k = 0; k < 40; k++) begin
            ra = rand_bcd();
            rb = ($urandom_range(0, 7) == 0) ? ra : rand_bcd();
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            do_op(ra, rb, rs, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
